// File: rtl/conv_frame_ctrl.sv
// conv_frame_ctrl: sequencer for the 3x3 convolution datapath.
// Counts pixel coordinates, holds the active kernel, applies mode
// changes only on frame boundaries and aligns valid/border flags
// with the filter pipeline latency.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   frame_start       start-of-frame pulse
//   pix_valid         one active pixel this cycle
//   mode_req/mode_sel kernel change request (0 byp,1 edge,2 gauss,3 sharp)
//   mode_ack          request latched as pending
//   x, y              coordinates of the current pixel
//   filt_en, kernel,
//   div_shift,
//   active_mode       currently applied kernel set
//   valid_out,
//   border_out        pix_valid / border flag delayed LAT cycles
//   frame_done        pulse aligned with the last delayed pixel
//   frame_cnt         completed frames (CONV_CTRL_STATS_EN), else 0
//
// Optional feature macro: CONV_CTRL_STATS_EN
module conv_frame_ctrl #(
  parameter int M   = 320,
  parameter int N   = 240,
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic        mode_req,
  input  logic [1:0]  mode_sel,
  output logic        mode_ack,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        filt_en,
  output logic [71:0] kernel,
  output logic [2:0]  div_shift,
  output logic [1:0]  active_mode,
  output logic        valid_out,
  output logic        border_out,
  output logic        frame_done,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [9:0] XMAX = 10'(M - 1);
  localparam logic [9:0] YMAX = 10'(N - 1);
  localparam logic [2:0] DLY  = 3'(LAT - 1);
  localparam logic       LAT1 = (LAT == 1);

  state_t         state;
  logic [2:0]     dcnt;
  logic [1:0]     pend;
  logic           pend_v;
  logic [LAT-1:0] vsr;
  logic [LAT-1:0] bsr;

  logic at_xmax;
  logic at_ymax;
  logic resync;
  logic drain_last;
  logic apply;
  logic is_border;

  assign at_xmax    = (x == XMAX);
  assign at_ymax    = (y == YMAX);
  assign resync     = (state == RUN) && frame_start;
  assign drain_last = (state == DRAIN) && (dcnt == 3'd0);
  assign is_border  = (x < 10'd2) || (y < 10'd2);

  // Boundaries where a pending mode may take effect.
  assign apply = pend_v &&
                 ((state == IDLE) || drain_last || resync);

  function automatic logic [71:0] kern_of(
    input logic [1:0] m
  );
    logic [71:0] k;
    k = '0;
    unique case (m)
      2'd0: k = 72'h00_00_00_00_00_00_00_00_00;
      2'd1: k = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;
      2'd2: k = 72'h01_02_01_02_04_02_01_02_01;
      2'd3: k = 72'h00_FF_00_FF_05_FF_00_FF_00;
      default: k = '0;
    endcase
    return k;
  endfunction

  function automatic logic [2:0] shift_of(
    input logic [1:0] m
  );
    return (m == 2'd2) ? 3'd4 : 3'd0;
  endfunction

  // Frame sequencer and coordinate counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      dcnt       <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          x <= '0;
          y <= '0;
          if (frame_start)
            state <= RUN;
        end
        RUN: begin
          if (frame_start) begin
            x <= '0;
            y <= '0;
          end else if (pix_valid) begin
            if (!at_xmax) begin
              x <= x + 10'd1;
            end else begin
              x <= '0;
              if (!at_ymax) begin
                y <= y + 10'd1;
              end else begin
                y     <= '0;
                state <= DRAIN;
                dcnt  <= DLY;
                // pulse lands with the last delayed pixel
                frame_done <= LAT1;
              end
            end
          end
        end
        DRAIN: begin
          if (dcnt == 3'd0) begin
            state <= frame_start ? RUN : IDLE;
          end else begin
            dcnt       <= dcnt - 3'd1;
            frame_done <= (dcnt == 3'd1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pending request and active kernel set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= '0;
      pend_v      <= 1'b0;
      mode_ack    <= 1'b0;
      active_mode <= '0;
      kernel      <= kern_of(2'd0);
      div_shift   <= shift_of(2'd0);
      filt_en     <= 1'b0;
    end else begin
      mode_ack <= mode_req;
      if (apply) begin
        active_mode <= pend;
        kernel      <= kern_of(pend);
        div_shift   <= shift_of(pend);
        filt_en     <= (pend != 2'd0);
      end
      // a request in the apply cycle waits for the next boundary
      if (mode_req) begin
        pend   <= mode_sel;
        pend_v <= 1'b1;
      end else if (apply) begin
        pend_v <= 1'b0;
      end
    end
  end

  // Valid/border delay line, shifting in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr <= '0;
      bsr <= '0;
    end else begin
      vsr[0] <= pix_valid;
      bsr[0] <= pix_valid && is_border;
      for (int i = 1; i < LAT; i++) begin
        vsr[i] <= vsr[i-1];
        bsr[i] <= bsr[i-1];
      end
    end
  end

  assign valid_out  = vsr[LAT-1];
  assign border_out = bsr[LAT-1];

`ifdef CONV_CTRL_STATS_EN
  logic [15:0] fcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fcnt <= '0;
    else if (drain_last)
      fcnt <= fcnt + 16'd1;
  end

  assign frame_cnt = fcnt;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// tb_conv_frame_ctrl: directed bench with scoreboard for conv_frame_ctrl.
// Small frame size keeps several full frames short.
module tb_conv_frame_ctrl;

  localparam int M   = 12;
  localparam int N   = 5;
  localparam int LAT = 3;

  localparam logic [71:0] K_BYP   = 72'h0;
  localparam logic [71:0] K_EDGE  = 72'hFF_FF_FF_FF_08_FF_FF_FF_FF;
  localparam logic [71:0] K_GAUSS = 72'h01_02_01_02_04_02_01_02_01;
  localparam logic [71:0] K_SHARP = 72'h00_FF_00_FF_05_FF_00_FF_00;

  logic        clk = 0;
  logic        rst;
  logic        frame_start;
  logic        pix_valid;
  logic        mode_req;
  logic [1:0]  mode_sel;
  logic        mode_ack;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        filt_en;
  logic [71:0] kernel;
  logic [2:0]  div_shift;
  logic [1:0]  active_mode;
  logic        valid_out;
  logic        border_out;
  logic        frame_done;
  logic [15:0] frame_cnt;

  conv_frame_ctrl #(.M(M), .N(N), .LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .pix_valid(pix_valid),
    .mode_req(mode_req), .mode_sel(mode_sel),
    .mode_ack(mode_ack), .x(x), .y(y),
    .filt_en(filt_en), .kernel(kernel),
    .div_shift(div_shift), .active_mode(active_mode),
    .valid_out(valid_out), .border_out(border_out),
    .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   cyc;
    logic b;
  } ent_t;

  ent_t bq[$];
  int   fq[$];
  ent_t me;
  int   mf;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mx = 0;
  int   my = 0;
  int   fc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [71:0] obs,
                     input logic [71:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard.
  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (bq.size() > 0 && bq[0].cyc == cyc) begin
        me = bq.pop_front();
        chk("valid_out", 72'(valid_out), 72'(1));
        chk("border_out", 72'(border_out), 72'(me.b));
      end else if (valid_out) begin
        chk("valid_stray", 72'(valid_out), 72'(0));
      end
      if (fq.size() > 0 && fq[0] == cyc) begin
        mf = fq.pop_front();
        chk("frame_done", 72'(frame_done), 72'(1));
      end else if (frame_done) begin
        chk("done_stray", 72'(frame_done), 72'(0));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pixel();
    pix_valid = 1'b1;
    bq.push_back('{cyc + LAT, (mx < 2) || (my < 2)});
    if (mx == M - 1) begin
      mx = 0;
      if (my == N - 1) begin
        my = 0;
        fq.push_back(cyc + LAT);
      end else begin
        my++;
      end
    end else begin
      mx++;
    end
    tick();
    pix_valid = 1'b0;
    chk("x", 72'(x), 72'(mx));
    chk("y", 72'(y), 72'(my));
  endtask

  task automatic run_px(input int n);
    for (int i = 0; i < n; i++) pixel();
  endtask

  task automatic req_px(input logic [1:0] m);
    mode_req = 1'b1;
    mode_sel = m;
    pixel();
    mode_req = 1'b0;
    chk("mode_ack", 72'(mode_ack), 72'(1));
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    mx = 0;
    my = 0;
    chk("start_xy", 72'({x, y}), 72'(0));
  endtask

  task automatic count_frame();
`ifdef CONV_CTRL_STATS_EN
    fc++;
`endif
    chk("frame_cnt", 72'(frame_cnt), 72'(fc));
  endtask

  task automatic end_frame();
    repeat (LAT) tick();
    count_frame();
  endtask

  task automatic chk_mode(input logic [1:0] m,
                          input logic [71:0] k,
                          input logic [2:0] sh,
                          input logic fe);
    chk("active_mode", 72'(active_mode), 72'(m));
    chk("kernel", kernel, k);
    chk("div_shift", 72'(div_shift), 72'(sh));
    chk("filt_en", 72'(filt_en), 72'(fe));
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_xy"}, 72'({x, y}), 72'(0));
    chk_mode(2'd0, K_BYP, 3'd0, 1'b0);
    chk({tag, "_flags"},
        72'({valid_out, border_out, frame_done, mode_ack}),
        72'(0));
    chk({tag, "_fcnt"}, 72'(frame_cnt), 72'(0));
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    mode_req = 1'b0;
    mode_sel = 2'd0;
    repeat (3) tick();
    chk_zero("rst");
    rst = 1'b0;
    tick();
    chk_zero("idle");

    // request in IDLE: ack next cycle, applied the cycle after
    mode_req = 1'b1;
    mode_sel = 2'd1;
    tick();
    mode_req = 1'b0;
    chk("idle_ack", 72'(mode_ack), 72'(1));
    chk("idle_pre", 72'(active_mode), 72'(0));
    tick();
    chk_mode(2'd1, K_EDGE, 3'd0, 1'b1);
    chk("ack_low", 72'(mode_ack), 72'(0));

    // frame 1: gaussian requested mid-frame
    start();
    run_px(20);
    req_px(2'd2);
    pixel();
    chk("hold_1", 72'(active_mode), 72'(1));
    run_px(M * N - 22);
    chk("drain_hold", 72'(active_mode), 72'(1));
    end_frame();
    chk_mode(2'd2, K_GAUSS, 3'd4, 1'b1);

    // frame 2: last request wins; early-drain start ignored,
    // start in last drain cycle restarts immediately
    start();
    run_px(5);
    req_px(2'd1);
    run_px(20);
    req_px(2'd3);
    chk("hold_2", 72'(active_mode), 72'(2));
    run_px(M * N - 27);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (LAT - 2) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    count_frame();
    mx = 0;
    my = 0;
    chk_mode(2'd3, K_SHARP, 3'd0, 1'b1);
    chk("center", 72'(kernel[39:32]), 72'(8'h05));

    // frame 3: resync at x=5, y=2 applies pending mode
    req_px(2'd2);
    run_px(2 * M + 4);
    chk("pre_resync", 72'({x, y}), 72'({10'd5, 10'd2}));
    start();
    chk_mode(2'd2, K_GAUSS, 3'd4, 1'b1);
    run_px(M * N);
    end_frame();
    chk("no_pend", 72'(active_mode), 72'(2));

    // reset mid-frame with a pending request
    start();
    run_px(8);
    req_px(2'd3);
    pixel();
    chk("x_at_10", 72'(x), 72'(10));
    rst = 1'b1;
    #1;
    bq.delete();
    fq.delete();
    fc = 0;
    mx = 0;
    my = 0;
    chk_zero("midrst");
    repeat (2) tick();
    rst = 1'b0;
    repeat (4) tick();
    chk_zero("postrst");

    // two full frames for the counter
    for (int f = 0; f < 2; f++) begin
      start();
      run_px(M * N);
      end_frame();
    end
`ifdef CONV_CTRL_STATS_EN
    chk("fcnt_two", 72'(frame_cnt), 72'(2));
`else
    chk("fcnt_two", 72'(frame_cnt), 72'(0));
`endif

    repeat (LAT + 3) tick();
    chk("bq_empty", 72'(bq.size()), 72'(0));
    chk("fq_empty", 72'(fq.size()), 72'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
